// File: rtl/ctrl_fsm.sv
// ============================================================================
//  Module   : ctrl_fsm
//  Brief    : Multi-cycle control unit for the 16-bit CPU. Sequences
//             fetch/decode/execute/memory/writeback for each instruction,
//             handshakes with instruction and data memory, and drives the
//             ALU select, operand muxes and datapath write strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_fsm #(
  parameter int WORD_SIZE = 16,
  parameter int OP_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] ir_in,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 dmem_byte,
  input  logic                 dmem_ack,
  input  logic                 alu_zero_flag,
  output logic [OP_SIZE-1:0]   alu_sel,
  output logic [1:0]           alu_src_b,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 reg_we,
  output logic                 reg_dst,
  output logic                 wb_src,
  output logic                 illegal,
  output logic [2:0]           state_dbg
);

  // --------------------------------------------------------------------------
  // Opcode, ALU and mux encodings
  // --------------------------------------------------------------------------
  localparam logic [OP_SIZE-1:0] c_OP_NOP  = 4'b0000;
  localparam logic [OP_SIZE-1:0] c_OP_LW   = 4'b0001;
  localparam logic [OP_SIZE-1:0] c_OP_LB   = 4'b0010;
  localparam logic [OP_SIZE-1:0] c_OP_SW   = 4'b0011;
  localparam logic [OP_SIZE-1:0] c_OP_SB   = 4'b0100;
  localparam logic [OP_SIZE-1:0] c_OP_AND  = 4'b0101;
  localparam logic [OP_SIZE-1:0] c_OP_SLT  = 4'b1001;
  localparam logic [OP_SIZE-1:0] c_OP_BEQ  = 4'b1010;
  localparam logic [OP_SIZE-1:0] c_OP_JUMP = 4'b1011;
  localparam logic [OP_SIZE-1:0] c_OP_ADDI = 4'b1100;

  localparam logic [OP_SIZE-1:0] c_ALU_IDLE = 4'b0000;
  localparam logic [OP_SIZE-1:0] c_ALU_ADD  = 4'b0111;
  localparam logic [OP_SIZE-1:0] c_ALU_SUB  = 4'b1000;

  localparam logic [1:0] c_SRCB_REG  = 2'd0;
  localparam logic [1:0] c_SRCB_IMM  = 2'd1;
  localparam logic [1:0] c_SRCB_ONE  = 2'd2;

  localparam logic [1:0] c_PC_ALU    = 2'd0;
  localparam logic [1:0] c_PC_BRANCH = 2'd1;
  localparam logic [1:0] c_PC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [OP_SIZE-1:0] op_q;

  // --------------------------------------------------------------------------
  // Opcode classification of the latched instruction
  // --------------------------------------------------------------------------
  logic w_is_rtype;
  logic w_is_load;
  logic w_is_store;
  logic w_is_byte;
  logic w_is_mem;
  logic w_is_beq;
  logic w_is_jump;
  logic w_is_addi;
  logic w_is_legal;

  assign w_is_rtype = (op_q >= c_OP_AND) && (op_q <= c_OP_SLT);
  assign w_is_load  = (op_q == c_OP_LW) || (op_q == c_OP_LB);
  assign w_is_store = (op_q == c_OP_SW) || (op_q == c_OP_SB);
  assign w_is_byte  = (op_q == c_OP_LB) || (op_q == c_OP_SB);
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_is_beq   = (op_q == c_OP_BEQ);
  assign w_is_jump  = (op_q == c_OP_JUMP);
  assign w_is_addi  = (op_q == c_OP_ADDI);
  assign w_is_legal = (op_q != c_OP_NOP) && (op_q <= c_OP_ADDI);

  // Only the opcode field is consumed here; operand fields go to the datapath.
  logic w_unused_ir;
  assign w_unused_ir = ^ir_in[WORD_SIZE-OP_SIZE-1:0];

  // Next-state selection; requests are held until the matching ack arrives.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (w_is_jump || !w_is_legal) state_d = S_FETCH;
        else                          state_d = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_rtype || w_is_addi) state_d = S_WB;
        else if (w_is_mem)           state_d = S_MEM;
        else                         state_d = S_FETCH;
      end
      S_MEM: begin
        if (dmem_ack) state_d = w_is_store ? S_FETCH : S_WB;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register and opcode latch; the opcode is captured with the IR load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= c_OP_NOP;
    end else begin
      state_q <= state_d;
      if (ir_we) op_q <= ir_in[WORD_SIZE-1 -: OP_SIZE];
    end
  end

  // Control outputs decoded from state and latched opcode; since the state
  // register resets asynchronously, every strobe and request drops with rst_n.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_byte = 1'b0;
    alu_sel   = c_ALU_IDLE;
    alu_src_b = c_SRCB_REG;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = c_PC_ALU;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wb_src    = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_FETCH: begin
        // ALU computes PC+1 while the fetch is outstanding.
        imem_req  = 1'b1;
        alu_sel   = c_ALU_ADD;
        alu_src_b = c_SRCB_ONE;
        ir_we     = imem_ack;
        pc_we     = imem_ack;
        pc_src    = c_PC_ALU;
      end
      S_DECODE: begin
        if (w_is_jump) begin
          pc_we  = 1'b1;
          pc_src = c_PC_JUMP;
        end else if (!w_is_legal) begin
          illegal = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_is_rtype) begin
          alu_sel   = op_q;
          alu_src_b = c_SRCB_REG;
        end else if (w_is_beq) begin
          alu_sel   = c_ALU_SUB;
          alu_src_b = c_SRCB_REG;
          pc_we     = alu_zero_flag;
          pc_src    = c_PC_BRANCH;
        end else if (w_is_addi || w_is_mem) begin
          alu_sel   = c_ALU_ADD;
          alu_src_b = c_SRCB_IMM;
        end
      end
      S_MEM: begin
        // Address computation is held stable for the whole access.
        dmem_req  = 1'b1;
        dmem_we   = w_is_store;
        dmem_byte = w_is_byte;
        alu_sel   = c_ALU_ADD;
        alu_src_b = c_SRCB_IMM;
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = w_is_rtype;
        wb_src  = w_is_load;
      end
      default: begin
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
// ============================================================================
//  Module   : tb_ctrl_fsm
//  Brief    : Scoreboard bench for ctrl_fsm. The stimulus process drives one
//             cycle at a time and queues the hand-computed expected outputs
//             for that cycle; a monitor pops and compares on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_byte;
    logic [3:0] alu_sel;
    logic [1:0] alu_src_b;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic       reg_dst;
    logic       wb_src;
    logic       illegal;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] ir_in;
  logic        imem_req, imem_ack;
  logic        dmem_req, dmem_we, dmem_byte, dmem_ack;
  logic        alu_zero_flag;
  logic [3:0]  alu_sel;
  logic [1:0]  alu_src_b;
  logic        ir_we, pc_we;
  logic [1:0]  pc_src;
  logic        reg_we, reg_dst, wb_src, illegal;
  logic [2:0]  state_dbg;

  ctrl_fsm #(.WORD_SIZE(16), .OP_SIZE(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ir_in         (ir_in),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_byte     (dmem_byte),
    .dmem_ack      (dmem_ack),
    .alu_zero_flag (alu_zero_flag),
    .alu_sel       (alu_sel),
    .alu_src_b     (alu_src_b),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .pc_src        (pc_src),
    .reg_we        (reg_we),
    .reg_dst       (reg_dst),
    .wb_src        (wb_src),
    .illegal       (illegal),
    .state_dbg     (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t  act;
  always_comb act = {state_dbg, imem_req, dmem_req, dmem_we, dmem_byte, alu_sel,
                     alu_src_b, ir_we, pc_we, pc_src, reg_we, reg_dst, wb_src, illegal};

  obs_t  exp_q[$];
  obs_t  msk_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  // Expected-value builders for each state; all values are supplied by hand.
  function automatic obs_t o_idle();
    obs_t o = '0;
    return o;
  endfunction

  function automatic obs_t o_fetch(logic ack);
    obs_t o = '0;
    o.st = 3'd1; o.imem_req = 1'b1; o.alu_sel = 4'b0111; o.alu_src_b = 2'd2;
    o.ir_we = ack; o.pc_we = ack; o.pc_src = 2'd0;
    return o;
  endfunction

  function automatic obs_t o_decode(logic pcwe, logic [1:0] pcsrc, logic ill);
    obs_t o = '0;
    o.st = 3'd2; o.pc_we = pcwe; o.pc_src = pcsrc; o.illegal = ill;
    return o;
  endfunction

  function automatic obs_t o_exec(logic [3:0] alu, logic [1:0] srcb, logic pcwe, logic [1:0] pcsrc);
    obs_t o = '0;
    o.st = 3'd3; o.alu_sel = alu; o.alu_src_b = srcb; o.pc_we = pcwe; o.pc_src = pcsrc;
    return o;
  endfunction

  function automatic obs_t o_mem(logic we, logic byt);
    obs_t o = '0;
    o.st = 3'd4; o.dmem_req = 1'b1; o.dmem_we = we; o.dmem_byte = byt;
    o.alu_sel = 4'b0111; o.alu_src_b = 2'd1;
    return o;
  endfunction

  function automatic obs_t o_wb(logic dst, logic src);
    obs_t o = '0;
    o.st = 3'd5; o.reg_we = 1'b1; o.reg_dst = dst; o.wb_src = src;
    return o;
  endfunction

  // Queue an expectation; qualifier fields are ignored where they carry no meaning.
  task automatic push(input obs_t e, input string t);
    obs_t m = '1;
    if (e.st != 3'd0) begin
      if (!e.dmem_req) begin m.dmem_we = 1'b0; m.dmem_byte = 1'b0; end
      if (!e.reg_we)   begin m.reg_dst = 1'b0; m.wb_src = 1'b0; end
      if (!e.pc_we)    m.pc_src = 2'b0;
      if (e.st == 3'd2 || e.st == 3'd5) begin m.alu_sel = 4'b0; m.alu_src_b = 2'b0; end
    end
    exp_q.push_back(e);
    msk_q.push_back(m);
    tag_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the DUT outputs of every queued cycle mid-period.
  initial begin
    obs_t  e, m, d;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        t = tag_q.pop_front();
        d = (act ^ e) & m;
        checks++;
        if (d != '0) begin
          errors++;
          $display("FAIL %s: got %h expected %h (mask %h)", t, act, e, m);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Directed instruction sequence
  initial begin
    rst_n = 1'b0; ir_in = 16'h7123; imem_ack = 1'b1; dmem_ack = 1'b0; alu_zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(o_idle(), "reset_state"); step();
    rst_n = 1'b1;
    push(o_idle(), "idle_after_release"); step();

    // ADD r3 = r1 + r2
    push(o_fetch(1'b1), "add_fetch"); step();
    push(o_decode(1'b0, 2'd0, 1'b0), "add_decode"); step();
    push(o_exec(4'b0111, 2'd0, 1'b0, 2'd0), "add_exec"); step();
    push(o_wb(1'b1, 1'b0), "add_wb"); step();

    // LW with data ack delayed three cycles
    ir_in = 16'h1452;
    push(o_fetch(1'b1), "lw_fetch"); step();
    push(o_decode(1'b0, 2'd0, 1'b0), "lw_decode"); step();
    push(o_exec(4'b0111, 2'd1, 1'b0, 2'd0), "lw_exec"); step();
    push(o_mem(1'b0, 1'b0), "lw_mem_wait1"); step();
    push(o_mem(1'b0, 1'b0), "lw_mem_wait2"); step();
    push(o_mem(1'b0, 1'b0), "lw_mem_wait3"); step();
    dmem_ack = 1'b1;
    push(o_mem(1'b0, 1'b0), "lw_mem_ack"); step();
    dmem_ack = 1'b0;
    push(o_wb(1'b0, 1'b1), "lw_wb"); step();

    // BEQ taken
    ir_in = 16'hA12F; alu_zero_flag = 1'b1;
    push(o_fetch(1'b1), "beq_t_fetch"); step();
    push(o_decode(1'b0, 2'd0, 1'b0), "beq_t_decode"); step();
    push(o_exec(4'b1000, 2'd0, 1'b1, 2'd1), "beq_t_exec"); step();

    // BEQ not taken
    alu_zero_flag = 1'b0;
    push(o_fetch(1'b1), "beq_nt_fetch"); step();
    push(o_decode(1'b0, 2'd0, 1'b0), "beq_nt_decode"); step();
    push(o_exec(4'b1000, 2'd0, 1'b0, 2'd0), "beq_nt_exec"); step();

    // JUMP: two-cycle instruction
    ir_in = 16'hB0FF;
    push(o_fetch(1'b1), "jump_fetch"); step();
    push(o_decode(1'b1, 2'd2, 1'b0), "jump_decode"); step();

    // Illegal opcode: single pulse, straight back to fetch
    ir_in = 16'hF000;
    push(o_fetch(1'b1), "ill_fetch"); step();
    push(o_decode(1'b0, 2'd0, 1'b1), "ill_decode"); step();

    // ADDI
    ir_in = 16'hC125;
    push(o_fetch(1'b1), "addi_fetch"); step();
    push(o_decode(1'b0, 2'd0, 1'b0), "addi_decode"); step();
    push(o_exec(4'b0111, 2'd1, 1'b0, 2'd0), "addi_exec"); step();
    push(o_wb(1'b0, 1'b0), "addi_wb"); step();

    // SW with immediate ack, returns to fetch without writeback
    ir_in = 16'h3452;
    push(o_fetch(1'b1), "sw_fetch"); step();
    push(o_decode(1'b0, 2'd0, 1'b0), "sw_decode"); step();
    push(o_exec(4'b0111, 2'd1, 1'b0, 2'd0), "sw_exec"); step();
    dmem_ack = 1'b1;
    push(o_mem(1'b1, 1'b0), "sw_mem_ack"); step();
    dmem_ack = 1'b0;

    // SB with a stalled fetch, then reset while the store is pending
    ir_in = 16'h4315; imem_ack = 1'b0;
    push(o_fetch(1'b0), "sb_fetch_wait"); step();
    imem_ack = 1'b1;
    push(o_fetch(1'b1), "sb_fetch"); step();
    push(o_decode(1'b0, 2'd0, 1'b0), "sb_decode"); step();
    push(o_exec(4'b0111, 2'd1, 1'b0, 2'd0), "sb_exec"); step();
    push(o_mem(1'b1, 1'b1), "sb_mem"); step();
    rst_n = 1'b0;
    push(o_idle(), "sb_reset_async"); step();
    push(o_idle(), "reset_held"); step();
    rst_n = 1'b1;
    push(o_idle(), "idle_after_rerelease"); step();
    ir_in = 16'h7123;
    push(o_fetch(1'b1), "restart_fetch"); step();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
